// File: rtl/uart_wave_cmd.sv
// uart_wave_cmd
// UART command receiver that drives a bank of waveform-generator channel
// settings. Bytes arrive on rx (8N1 by default) and are parsed as single
// letter commands, channel-select digits, or 'F' followed by a hex
// frequency word.
//
// Ports
//   clk            in   single clock
//   rst_n          in   synchronous active-low reset
//   rx             in   asynchronous UART input, idle high
//   wave_select    out  3 bits per channel, channel c at [3c+2:3c]
//   white_noise_en out  1 bit per channel
//   freq_word      out  FREQ_W bits per channel, channel c at [FREQ_W*c +: FREQ_W]
//   cmd_valid      out  one-cycle pulse when a command commits
//   cmd_error      out  one-cycle pulse on a rejected byte or command
//
// Build option
//   UART_PARITY_EN  when defined, frames carry an even-parity bit between
//                   the data bits and the stop bit.
//
// Receiver states
//   state     | meaning
//   RX_IDLE   | waiting for a start edge (or for rx high after a framing error)
//   RX_START  | timing to the middle of the start bit
//   RX_DATA   | sampling 8 data bits, LSB first
//   RX_PARITY | sampling the even-parity bit (UART_PARITY_EN only)
//   RX_STOP   | sampling the stop bit, emits byte strobe or error
//
// Parser states
//   state     | meaning
//   P_IDLE    | decoding single-byte commands
//   P_FREQ    | collecting hex digits of a frequency word

module uart_wave_cmd #(
  parameter int                CLK_HZ   = 25000000,
  parameter int                BAUD     = 9600,
  parameter int                NUM_CH   = 2,
  parameter int                FREQ_W   = 16,
  parameter logic [FREQ_W-1:0] FREQ_RST = FREQ_W'(16'h0100)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [3*NUM_CH-1:0]      wave_select,
  output logic [NUM_CH-1:0]        white_noise_en,
  output logic [FREQ_W*NUM_CH-1:0] freq_word,
  output logic                     cmd_valid,
  output logic                     cmd_error
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);
  localparam logic [7:0] ND_M1    = 8'(FREQ_W / 4 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    P_IDLE,
    P_FREQ
  } p_state_e;

  // ---------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  rx_state_e     rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shr_q, shr_d;
  logic          wait_hi_q, wait_hi_d;
  logic          byte_stb;
  logic          rx_err;
`ifdef UART_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_st_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shr_q     <= '0;
      wait_hi_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_st_q   <= rx_st_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shr_q     <= shr_d;
      wait_hi_q <= wait_hi_d;
`ifdef UART_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    rx_st_d   = rx_st_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shr_d     = shr_q;
    wait_hi_d = wait_hi_q;
    byte_stb  = 1'b0;
    rx_err    = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (rx_st_q)
      RX_IDLE: begin
        // After a framing error the line may still be low; a start edge is
        // only accepted once the line has been seen idle again.
        if (wait_hi_q) begin
          if (rx_sync_q) wait_hi_d = 1'b0;
        end else if (!rx_sync_q) begin
          rx_st_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_st_d = RX_DATA;
            cnt_d   = DIV_M1;
            bit_d   = 3'd0;
          end else begin
            rx_st_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shr_d = {rx_sync_q, shr_q[7:1]};
          cnt_d = DIV_M1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_st_d = RX_PARITY;
`else
            rx_st_d = RX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == '0) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_err_d = ^{shr_q, rx_sync_q};
          rx_st_d   = RX_STOP;
          cnt_d     = DIV_M1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == '0) begin
          rx_st_d = RX_IDLE;
          if (!rx_sync_q) begin
            rx_err    = 1'b1;
            wait_hi_d = 1'b1;
`ifdef UART_PARITY_EN
          end else if (par_err_q) begin
            rx_err = 1'b1;
`endif
          end else begin
            byte_stb = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Command parser
  // ---------------------------------------------------------------------
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= "0" && c <= "9")      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= "A" && c <= "F") r = {1'b1, 4'(c - 8'h37)};
    else if (c >= "a" && c <= "f") r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  p_state_e                p_st_q, p_st_d;
  logic [7:0]              dcnt_q, dcnt_d;
  logic [FREQ_W-1:0]       acc_q, acc_d;
  logic [3:0]              chan_q, chan_d;
  logic [3*NUM_CH-1:0]     wave_q, wave_d;
  logic [NUM_CH-1:0]       noise_q, noise_d;
  logic [FREQ_W*NUM_CH-1:0] freq_q, freq_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;

  logic [7:0]        rx_byte;
  logic [4:0]        hex;
  logic [FREQ_W-1:0] acc_next;

  assign rx_byte  = shr_q;
  assign hex      = hex_nib(rx_byte);
  assign acc_next = (acc_q << 4) | FREQ_W'(hex[3:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_st_q  <= P_IDLE;
      dcnt_q  <= '0;
      acc_q   <= '0;
      chan_q  <= '0;
      wave_q  <= '0;
      noise_q <= '0;
      freq_q  <= {NUM_CH{FREQ_RST}};
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      p_st_q  <= p_st_d;
      dcnt_q  <= dcnt_d;
      acc_q   <= acc_d;
      chan_q  <= chan_d;
      wave_q  <= wave_d;
      noise_q <= noise_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    p_st_d  = p_st_q;
    dcnt_d  = dcnt_q;
    acc_d   = acc_q;
    chan_d  = chan_q;
    wave_d  = wave_q;
    noise_d = noise_q;
    freq_d  = freq_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    // A receiver error discards the byte and leaves any FREQ command open.
    if (rx_err) begin
      error_d = 1'b1;
    end else if (byte_stb) begin
      case (p_st_q)
        P_IDLE: begin
          case (rx_byte)
            "Q": begin wave_d[3*int'(chan_q) +: 3] = 3'b000; valid_d = 1'b1; end
            "S": begin wave_d[3*int'(chan_q) +: 3] = 3'b001; valid_d = 1'b1; end
            "T": begin wave_d[3*int'(chan_q) +: 3] = 3'b010; valid_d = 1'b1; end
            "I": begin wave_d[3*int'(chan_q) +: 3] = 3'b011; valid_d = 1'b1; end
            "W": begin noise_d[chan_q] = 1'b1; valid_d = 1'b1; end
            "w": begin noise_d[chan_q] = 1'b0; valid_d = 1'b1; end
            "F": begin
              p_st_d = P_FREQ;
              dcnt_d = '0;
              acc_d  = '0;
            end
            8'h0D, 8'h0A, 8'h20: ;
            default: begin
              if (rx_byte >= "0" && rx_byte <= "9" && (rx_byte - 8'h30) < NUM_CH_B) begin
                chan_d  = 4'(rx_byte - 8'h30);
                valid_d = 1'b1;
              end else begin
                error_d = 1'b1;
              end
            end
          endcase
        end
        P_FREQ: begin
          if (hex[4]) begin
            acc_d = acc_next;
            if (dcnt_q == ND_M1) begin
              freq_d[FREQ_W*int'(chan_q) +: FREQ_W] = acc_next;
              valid_d = 1'b1;
              p_st_d  = P_IDLE;
            end else begin
              dcnt_d = dcnt_q + 8'd1;
            end
          end else begin
            error_d = 1'b1;
            p_st_d  = P_IDLE;
          end
        end
        default: p_st_d = P_IDLE;
      endcase
    end
  end

  assign wave_select    = wave_q;
  assign white_noise_en = noise_q;
  assign freq_word      = freq_q;
  assign cmd_valid      = valid_q;
  assign cmd_error      = error_q;

endmodule

// File: doc/uart_wave_cmd.md
UART_WAVE_CMD -- requirements
Module: uart_wave_cmd

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 25000000, meaning the clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the UART bit rate.
REQ-003 The block SHALL have parameter NUM_CH, default 2 (range 1..10), meaning the number of wave channels.
REQ-004 The block SHALL have parameter FREQ_W, default 16 (multiple of 4), meaning the frequency word width per channel.
REQ-005 The block SHALL have parameter FREQ_RST, default 16'h0100, meaning the frequency word value after reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port rx, input, 1 bit: asynchronous UART serial input, idle high.
REQ-009 The block SHALL have port wave_select, output, 3*NUM_CH bits: channel c occupies bits [3c+2:3c].
REQ-010 The block SHALL have port white_noise_en, output, NUM_CH bits: per-channel noise enable.
REQ-011 The block SHALL have port freq_word, output, FREQ_W*NUM_CH bits: channel c occupies bits [FREQ_W*c+FREQ_W-1:FREQ_W*c].
REQ-012 The block SHALL have port cmd_valid, output, 1 bit: one-cycle pulse when a command commits.
REQ-013 The block SHALL have port cmd_error, output, 1 bit: one-cycle pulse on a rejected byte or command.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-015 DIV SHALL equal CLK_HZ/BAUD, integer, rounded down; the receiver SHALL sample at DIV/2 clocks after the start edge, then every DIV clocks.
REQ-016 Receiver states SHALL be IDLE, START, DATA (8 bits, LSB first), [PARITY], STOP.
- START sampled high -> return to IDLE with no byte and no error.
REQ-017 A STOP sample of 0 SHALL discard the byte and pulse cmd_error; the receiver SHALL then wait for rx high before re-arming.
REQ-018 A good byte SHALL produce an internal strobe at the STOP sample; outputs and cmd_valid/cmd_error SHALL update exactly 1 clock later.
REQ-019 Parser state IDLE SHALL decode wave letters into the current channel's wave_select:
- 'Q' = 000 (square)
- 'S' = 001 (sawtooth)
- 'T' = 010 (triangle)
- 'I' = 011 (sine)
Each such letter pulses cmd_valid.
REQ-020 In parser state IDLE, 'W' SHALL set and 'w' SHALL clear white_noise_en of the current channel, and pulse cmd_valid.
REQ-021 In parser state IDLE, ASCII digit d SHALL set the current channel to d and pulse cmd_valid if d < NUM_CH; otherwise it SHALL pulse cmd_error with no change.
REQ-022 In parser state IDLE, 'F' SHALL enter parser state FREQ with the digit count cleared; no pulse is issued.
REQ-023 In parser state FREQ, each hex digit (0-9, A-F, a-f) SHALL shift into an accumulator MSB-first.
- After FREQ_W/4 digits: commit to freq_word of the current channel, pulse cmd_valid, return to IDLE.
REQ-024 In parser state FREQ, any non-hex byte SHALL abort: pulse cmd_error, leave freq_word unchanged, return to IDLE, and not interpret the byte otherwise.
REQ-025 In parser state IDLE, CR, LF and space SHALL be ignored silently; any other byte SHALL pulse cmd_error.
REQ-026 cmd_valid and cmd_error SHALL never assert in the same cycle.
REQ-027 The current channel SHALL persist across commands.

Reset
REQ-028 While rst_n is low at a clk edge, all of the following SHALL take their reset values:
- wave_select: all 0
- white_noise_en: all 0
- freq_word: every channel = FREQ_RST
- current channel: 0
- cmd_valid, cmd_error: 0
- receiver and parser: IDLE, counters cleared
REQ-029 Reset mid-frame SHALL discard the partial byte and any partial FREQ command.

Configuration
REQ-030 With macro UART_PARITY_EN defined, the receiver SHALL expect an even-parity bit between DATA and STOP.
- Parity mismatch: discard the byte and pulse cmd_error, with no parser effect.
- Without the macro: 8N1 framing and no parity state.

Verification (CLK_HZ=25000000, BAUD=9600, bit time 104167 ns, macro off)
REQ-031 After reset, send 'T' -> wave_select[2:0]=010 and exactly one cmd_valid pulse; wave_select[5:3]=000.
REQ-032 Send '1' then 'S' -> wave_select[5:3]=001; wave_select[2:0] unchanged; white_noise_en=00.
REQ-033 Send 'F','1','2','a','B' -> freq_word[15:0]=16'h12AB after the 4th digit; freq_word[31:16]=16'h0100.
REQ-034 Send 'F','1','G', then 'W' -> one cmd_error, freq_word unchanged, then white_noise_en[0]=1.
- Send '9' -> cmd_error, no change.
REQ-035 Send 'T' with stop bit driven 0 -> cmd_error, wave_select unchanged; the next valid 'S' decodes correctly.
REQ-036 Assert rst_n low for 3 clocks during data bit 4 of 'I' -> all outputs at reset values; the following 'I' sets wave_select[2:0]=011.
